// File: rtl/fix_pkg.sv
// Shared FIX order-entry definitions: exec_type ASCII codes, sides, field widths,
// the live-order table entry layout and the terminal-state test.
package fix_pkg;
  localparam int CLORDID_W = 64;
  localparam int QTY_W     = 32;
  localparam int PX_W      = 32;

  localparam logic [7:0] EXEC_NEW       = 8'h30; // '0'
  localparam logic [7:0] EXEC_CANCELED  = 8'h34; // '4'
  localparam logic [7:0] EXEC_REPLACE   = 8'h35; // '5'
  localparam logic [7:0] EXEC_REJECTED  = 8'h38; // '8'
  localparam logic [7:0] EXEC_EXPIRED   = 8'h43; // 'C'
  localparam logic [7:0] EXEC_TRADE     = 8'h46; // 'F'
  localparam logic [7:0] ORD_PENDING    = 8'h41; // 'A' status of a freshly registered order

  localparam logic SIDE_BUY  = 1'b0;
  localparam logic SIDE_SELL = 1'b1;

  typedef struct packed {
    logic                 valid;
    logic [CLORDID_W-1:0] clordid;
    logic                 side;
    logic [QTY_W-1:0]     qty;
    logic [QTY_W-1:0]     cum_qty;
    logic [QTY_W-1:0]     leaves_qty;
    logic [7:0]           status;
  } ord_ent_t;

  // An order leaves the book on cancel/reject/expire, or on a trade that exhausts it.
  function automatic logic is_terminal(input logic [7:0] exec_type,
                                       input logic [QTY_W-1:0] leaves_qty);
    return (exec_type == EXEC_CANCELED) || (exec_type == EXEC_REJECTED) ||
           (exec_type == EXEC_EXPIRED)  ||
           ((exec_type == EXEC_TRADE) && (leaves_qty == '0));
  endfunction
endpackage

// File: rtl/ost_slot_alloc.sv
// Lowest-index free slot finder over the table valid vector.
module ost_slot_alloc #(
  parameter  int DEPTH = 8,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] valid_vec,
  output logic [IW-1:0]    free_idx,
  output logic             any_free
);
  // Scan from the top down so the lowest free index wins.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!valid_vec[i]) free_idx = IW'(i);
    any_free = ~&valid_vec;
  end
endmodule

// File: rtl/order_state_tracker.sv
// Live-order table: registers strategy orders, matches decoded execution reports by
// client order id, emits fill/done pulses and tracks signed net position.
module order_state_tracker
  import fix_pkg::*;
#(
  parameter  int DEPTH = 8,
  parameter  int POS_W = 32,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    reg_valid,
  output logic                    reg_ready,
  input  logic [CLORDID_W-1:0]    reg_clordid,
  input  logic                    reg_side,
  input  logic [QTY_W-1:0]        reg_qty,
  output logic                    reg_dup_err,
  input  logic                    exec_valid,
  input  logic [CLORDID_W-1:0]    exec_clordid,
  input  logic [7:0]              exec_type,
  input  logic [7:0]              exec_status,
  input  logic [QTY_W-1:0]        exec_cum_qty,
  input  logic [QTY_W-1:0]        exec_leaves_qty,
  input  logic [QTY_W-1:0]        exec_last_qty,
  input  logic [PX_W-1:0]         exec_last_price,
  output logic                    fill_valid,
  output logic [IW-1:0]           fill_slot,
  output logic                    fill_side,
  output logic [QTY_W-1:0]        fill_qty,
  output logic [PX_W-1:0]         fill_price,
  output logic                    order_done,
  output logic signed [POS_W-1:0] net_position,
  output logic [IW:0]             live_count,
  output logic [31:0]             unmatched_count
);
  ord_ent_t ent_q [DEPTH];
  ord_ent_t ent_d [DEPTH];

  logic                    fill_valid_q, fill_valid_d;
  logic [IW-1:0]           fill_slot_q, fill_slot_d;
  logic                    fill_side_q, fill_side_d;
  logic [QTY_W-1:0]        fill_qty_q, fill_qty_d;
  logic [PX_W-1:0]         fill_price_q, fill_price_d;
  logic                    order_done_q, order_done_d;
  logic                    reg_dup_err_q, reg_dup_err_d;
  logic signed [POS_W-1:0] net_q, net_d;
  logic [IW:0]             live_q, live_d;
  logic [31:0]             unmatched_q, unmatched_d;

  logic [DEPTH-1:0] valid_vec, hit_vec, dup_vec;
  logic [IW-1:0]    hit_idx, free_idx;
  logic             any_free;

  // Parallel id compare per entry, always against the pre-update table.
  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    assign valid_vec[g] = ent_q[g].valid;
    assign hit_vec[g]   = ent_q[g].valid && (ent_q[g].clordid == exec_clordid);
    assign dup_vec[g]   = ent_q[g].valid && (ent_q[g].clordid == reg_clordid);
  end

  ost_slot_alloc #(.DEPTH(DEPTH)) u_alloc (
    .valid_vec (valid_vec),
    .free_idx  (free_idx),
    .any_free  (any_free)
  );

  assign reg_ready = (live_q != (IW+1)'(DEPTH));

  // Ids are unique so at most one hit bit is set; OR-encode it.
  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (hit_vec[i]) hit_idx = hit_idx | IW'(i);
  end

  // Next-state: exec update first, then registration into a slot that was free before this cycle.
  always_comb begin
    logic reg_acc, reg_wr, hit, freed;
    ent_d         = ent_q;
    fill_valid_d  = 1'b0;
    fill_slot_d   = fill_slot_q;
    fill_side_d   = fill_side_q;
    fill_qty_d    = fill_qty_q;
    fill_price_d  = fill_price_q;
    order_done_d  = 1'b0;
    net_d         = net_q;
    unmatched_d   = unmatched_q;
    reg_acc       = reg_valid && reg_ready;
    reg_dup_err_d = reg_acc && (|dup_vec);
    reg_wr        = reg_acc && !(|dup_vec) && any_free;
    hit           = exec_valid && (|hit_vec);
    freed         = 1'b0;

    if (exec_valid && !hit) unmatched_d = unmatched_q + 32'd1;

    if (hit) begin
      ent_d[hit_idx].cum_qty    = exec_cum_qty;
      ent_d[hit_idx].leaves_qty = exec_leaves_qty;
      ent_d[hit_idx].status     = exec_status;
      if (exec_type == EXEC_TRADE) begin
        fill_valid_d = 1'b1;
        fill_slot_d  = hit_idx;
        fill_side_d  = ent_q[hit_idx].side;
        fill_qty_d   = exec_last_qty;
        fill_price_d = exec_last_price;
        if (ent_q[hit_idx].side == SIDE_SELL) net_d = net_q - POS_W'(exec_last_qty);
        else                                  net_d = net_q + POS_W'(exec_last_qty);
      end
      if (is_terminal(exec_type, exec_leaves_qty)) begin
        ent_d[hit_idx].valid = 1'b0;
        order_done_d         = 1'b1;
        freed                = 1'b1;
      end
    end

    if (reg_wr)
      ent_d[free_idx] = '{valid: 1'b1, clordid: reg_clordid, side: reg_side, qty: reg_qty,
                          cum_qty: '0, leaves_qty: reg_qty, status: ORD_PENDING};

    live_d = live_q + (IW+1)'(reg_wr) - (IW+1)'(freed);
  end

  // State and registered outputs; reset wipes the whole book.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      fill_valid_q  <= 1'b0;
      fill_slot_q   <= '0;
      fill_side_q   <= 1'b0;
      fill_qty_q    <= '0;
      fill_price_q  <= '0;
      order_done_q  <= 1'b0;
      reg_dup_err_q <= 1'b0;
      net_q         <= '0;
      live_q        <= '0;
      unmatched_q   <= '0;
    end else begin
      ent_q         <= ent_d;
      fill_valid_q  <= fill_valid_d;
      fill_slot_q   <= fill_slot_d;
      fill_side_q   <= fill_side_d;
      fill_qty_q    <= fill_qty_d;
      fill_price_q  <= fill_price_d;
      order_done_q  <= order_done_d;
      reg_dup_err_q <= reg_dup_err_d;
      net_q         <= net_d;
      live_q        <= live_d;
      unmatched_q   <= unmatched_d;
    end
  end

  assign fill_valid      = fill_valid_q;
  assign fill_slot       = fill_slot_q;
  assign fill_side       = fill_side_q;
  assign fill_qty        = fill_qty_q;
  assign fill_price      = fill_price_q;
  assign order_done      = order_done_q;
  assign reg_dup_err     = reg_dup_err_q;
  assign net_position    = net_q;
  assign live_count      = live_q;
  assign unmatched_count = unmatched_q;
endmodule

// File: tb/tb_order_state_tracker.sv
// Directed bench for order_state_tracker (DEPTH=8, POS_W=32).
module tb_order_state_tracker;
  localparam int DEPTH = 8;
  localparam int IW    = 3;

  logic        clk = 1'b0;
  logic        rstn;
  logic        reg_valid, reg_ready, reg_side, reg_dup_err;
  logic [63:0] reg_clordid;
  logic [31:0] reg_qty;
  logic        exec_valid;
  logic [63:0] exec_clordid;
  logic [7:0]  exec_type, exec_status;
  logic [31:0] exec_cum_qty, exec_leaves_qty, exec_last_qty, exec_last_price;
  logic        fill_valid, fill_side, order_done;
  logic [IW-1:0] fill_slot;
  logic [31:0] fill_qty, fill_price, unmatched_count;
  logic signed [31:0] net_position;
  logic [IW:0] live_count;

  int vectors = 0;
  int miscompares = 0;

  order_state_tracker #(.DEPTH(DEPTH), .POS_W(32)) dut (
    .clk(clk), .rstn(rstn),
    .reg_valid(reg_valid), .reg_ready(reg_ready), .reg_clordid(reg_clordid),
    .reg_side(reg_side), .reg_qty(reg_qty), .reg_dup_err(reg_dup_err),
    .exec_valid(exec_valid), .exec_clordid(exec_clordid), .exec_type(exec_type),
    .exec_status(exec_status), .exec_cum_qty(exec_cum_qty), .exec_leaves_qty(exec_leaves_qty),
    .exec_last_qty(exec_last_qty), .exec_last_price(exec_last_price),
    .fill_valid(fill_valid), .fill_slot(fill_slot), .fill_side(fill_side),
    .fill_qty(fill_qty), .fill_price(fill_price), .order_done(order_done),
    .net_position(net_position), .live_count(live_count), .unmatched_count(unmatched_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reg(input logic [63:0] id, input logic side, input logic [31:0] qty);
    reg_valid = 1'b1; reg_clordid = id; reg_side = side; reg_qty = qty;
  endtask

  task automatic set_exec(input logic [63:0] id, input logic [7:0] et,
                          input logic [31:0] cum, input logic [31:0] leaves,
                          input logic [31:0] last, input logic [31:0] px);
    exec_valid = 1'b1; exec_clordid = id; exec_type = et; exec_status = et;
    exec_cum_qty = cum; exec_leaves_qty = leaves; exec_last_qty = last; exec_last_price = px;
  endtask

  task automatic idle();
    reg_valid = 1'b0; exec_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, reg_ready, 1);
    chk({tag, "_live"}, live_count, 0);
    chk({tag, "_net"}, net_position, 0);
    chk({tag, "_unm"}, unmatched_count, 0);
    chk({tag, "_fillv"}, fill_valid, 0);
    chk({tag, "_fillq"}, fill_qty, 0);
    chk({tag, "_done"}, order_done, 0);
    chk({tag, "_dup"}, reg_dup_err, 0);
  endtask

  initial begin
    rstn = 1'b0;
    reg_valid = 0; reg_clordid = '0; reg_side = 0; reg_qty = '0;
    exec_valid = 0; exec_clordid = '0; exec_type = '0; exec_status = '0;
    exec_cum_qty = '0; exec_leaves_qty = '0; exec_last_qty = '0; exec_last_price = '0;
    #12;
    chk_reset_vals("rst");
    rstn = 1'b1;
    tick();

    // 1: partial buy fill
    set_reg(64'h1001, 1'b0, 100); tick(); idle();
    chk("t1_live_reg", live_count, 1);
    set_exec(64'h1001, "F", 40, 60, 40, 500); tick(); idle();
    chk("t1_fillv", fill_valid, 1);
    chk("t1_fillq", fill_qty, 40);
    chk("t1_fillpx", fill_price, 500);
    chk("t1_fillslot", fill_slot, 0);
    chk("t1_fillside", fill_side, 0);
    chk("t1_net", net_position, 40);
    chk("t1_live", live_count, 1);
    chk("t1_done", order_done, 0);

    // 2: completing fill -> fill and done together
    set_exec(64'h1001, "F", 100, 0, 60, 510); tick(); idle();
    chk("t2_fillv", fill_valid, 1);
    chk("t2_done", order_done, 1);
    chk("t2_net", net_position, 100);
    chk("t2_live", live_count, 0);
    tick();
    chk("t2_fillv_drop", fill_valid, 0);
    chk("t2_done_drop", order_done, 0);

    // 3: sell registered then canceled; slot 0 reused
    set_reg(64'h2002, 1'b1, 50); tick(); idle();
    set_exec(64'h2002, "4", 0, 0, 0, 0); tick(); idle();
    chk("t3_done", order_done, 1);
    chk("t3_fillv", fill_valid, 0);
    chk("t3_net", net_position, 100);
    chk("t3_live", live_count, 0);
    set_reg(64'h2003, 1'b0, 10); tick(); idle();
    set_exec(64'h2003, "F", 10, 0, 10, 7); tick(); idle();
    chk("t3_reuse_slot", fill_slot, 0);
    chk("t3_net2", net_position, 110);

    // 4: fill the table, hold a 9th registration, cancel slot 3
    for (int i = 0; i < DEPTH; i++) begin
      set_reg(64'h4000 + 64'(i), (i == 7) ? 1'b1 : 1'b0, 1); tick();
    end
    idle();
    chk("t4_live_full", live_count, 8);
    chk("t4_ready_full", reg_ready, 0);
    set_reg(64'h4008, 1'b0, 1); tick();
    chk("t4_held_live", live_count, 8);
    set_exec(64'h4003, "4", 0, 0, 0, 0); tick(); exec_valid = 1'b0;
    chk("t4_cancel_done", order_done, 1);
    chk("t4_cancel_live", live_count, 7);
    chk("t4_ready_back", reg_ready, 1);
    tick(); idle();
    chk("t4_landed_live", live_count, 8);
    chk("t4_ready_full2", reg_ready, 0);
    set_exec(64'h4008, "F", 1, 0, 1, 20); tick(); idle();
    chk("t4_landed_slot", fill_slot, 3);
    chk("t4_net", net_position, 111);
    set_exec(64'h4007, "F", 5, 0, 5, 21); tick(); idle();
    chk("t4_sell_slot", fill_slot, 7);
    chk("t4_sell_side", fill_side, 1);
    chk("t4_sell_net", net_position, 106);
    chk("t4_live6", live_count, 6);

    // 5: unknown id, then same-cycle register+exec of 0x3003
    set_exec(64'hDEAD, "F", 1, 0, 1, 1); tick(); idle();
    chk("t5_unm1", unmatched_count, 1);
    chk("t5_nofill", fill_valid, 0);
    set_reg(64'h3003, 1'b0, 9); set_exec(64'h3003, "F", 9, 0, 9, 3); tick(); idle();
    chk("t5_unm2", unmatched_count, 2);
    chk("t5_nofill2", fill_valid, 0);
    chk("t5_net", net_position, 106);
    chk("t5_live", live_count, 7);
    chk("t5_slot3_id", dut.ent_q[3].clordid, 64'h3003);
    chk("t5_slot3_status", dut.ent_q[3].status, 8'h41);
    // same-cycle free + register: freed slot 0 not reused, new order goes to slot 7
    set_reg(64'h5005, 1'b0, 7); set_exec(64'h4000, "8", 0, 0, 0, 0); tick(); idle();
    chk("t5_swap_done", order_done, 1);
    chk("t5_swap_live", live_count, 7);
    set_exec(64'h5005, "F", 2, 5, 2, 9); tick(); idle();
    chk("t5_swap_slot", fill_slot, 7);
    chk("t5_swap_net", net_position, 108);
    chk("t5_partial_nodone", order_done, 0);

    // 6: duplicate registration, expire, non-terminal update, async reset
    set_reg(64'h4001, 1'b0, 3); tick(); idle();
    chk("t6_dup", reg_dup_err, 1);
    chk("t6_dup_live", live_count, 7);
    tick();
    chk("t6_dup_drop", reg_dup_err, 0);
    set_exec(64'h4001, "C", 0, 0, 0, 0); tick(); idle();
    chk("t6_exp_done", order_done, 1);
    chk("t6_exp_live", live_count, 6);
    set_exec(64'h4002, "0", 0, 1, 0, 0); tick(); idle();
    chk("t6_new_done", order_done, 0);
    chk("t6_new_live", live_count, 6);
    set_exec(64'h4002, "F", 1, 0, 1, 4); #3;
    rstn = 1'b0; #1;
    idle();
    chk_reset_vals("arst");
    chk("arst_tbl", dut.ent_q[2].valid, 0);
    tick();
    rstn = 1'b1;
    tick();
    chk("post_rst_live", live_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
